icache_ctrl: RTL and testbench
==============================

Name: icache_ctrl

Overview:
Instruction-side responder to the IF stage fetch interface.
- Takes the fetch PC and the cache-enable flag, and returns the instruction word, a hit flag and a freeze request.
- On a miss, freezes the IF stage and refills a line from main memory over a word-serial request/valid handshake.
- Direct-mapped, read-only cache with an uncached bypass path.

Parameters:
LINE_WORDS, 4, 32-bit words per line (power of 2, ≥2)
NUM_LINES, 16, lines in cache (power of 2)

Ports:
clk  in  1  clock
rst_b  in  1  reset
pc  in  32  fetch address from IF stage; pc[1:0] ignored
cache_en  in  1  1 = cached fetch, 0 = uncached bypass
flush  in  1  invalidate all lines
inst  out  32  instruction for pc
hit  out  1  cached lookup hit this cycle
freeze  out  1  stall request to IF stage (holds pc)
mem_req  out  1  word read request to main memory
mem_addr  out  32  word-aligned read address
mem_rvalid  in  1  read data valid; completes current request
mem_rdata  in  32  read data

Behaviour:
- Reset rst_b: asynchronous, active-low. Clock clk: rising edge.
- Reset state:
  - state=IDLE, all valid bits 0, word counter 0, mem_req=0, mem_addr=0, bypass register 0.
  - inst=0 and hit=0.
  - freeze follows the combinational rule below, so after reset with cache_en=1 freeze=1 at once.
- Address split:
  - offset = pc[OFF-1:0], with OFF = log2(LINE_WORDS)+2.
  - index = next log2(NUM_LINES) bits.
  - tag = remaining upper bits.
- Lookup is combinational in IDLE: hit = cache_en & valid[index] & (tag_mem[index]==tag).
- Output rules:
  - inst = data word at index/offset when hit.
  - inst = bypass register in BYP_DONE.
  - inst = 0 otherwise.
  - hit = 0 in every state other than IDLE.
- freeze:
  - 1 in IDLE when a miss occurs (cache_en & !hit), or when cache_en=0.
  - 1 in REFILL and BYPASS.
  - 0 in BYP_DONE.
  - 0 in IDLE on a hit.
- FSM states: IDLE, REFILL, BYPASS, BYP_DONE.
  - IDLE, cache_en=1 and miss: latch line base = {pc[31:OFF], 0}, latch index/tag, counter=0, go REFILL.
  - IDLE, cache_en=0: latch {pc[31:2],00}, go BYPASS.
  - REFILL:
    - mem_req=1, mem_addr = base + 4*counter.
    - Each cycle with mem_rvalid: write mem_rdata to word[counter], counter++.
    - When counter==LINE_WORDS-1 and mem_rvalid: write tag, set valid, go IDLE.
    - The following cycle re-looks up and hits.
  - BYPASS: mem_req=1, mem_addr = latched word address. On mem_rvalid: capture data, go BYP_DONE. No line is allocated.
  - BYP_DONE: single cycle with freeze=0, inst=captured data; the IF stage advances. Then go IDLE.
- Handshake:
  - mem_req and mem_addr are registered and stable until mem_rvalid.
  - Back-to-back mem_rvalid is legal; the address advances the next cycle.
  - mem_rvalid while mem_req=0 is ignored.
  - Latency is unbounded.
- Miss penalty: 1 + Σ(memory latencies) cycles. A hit costs 0 stall cycles.
- Flush (synchronous):
  - Clears all valid bits in any state.
  - During REFILL, sets a suppress flag so the finishing line is not validated. The FSM still completes the refill and returns to IDLE, where it misses again.
  - Flush coinciding with the final mem_rvalid: flush wins (line invalid).
  - Flush in IDLE on a hit: hit stays 1 for that cycle (lookup precedes the clock edge); invalidation takes effect next cycle.
- Changes of pc or cache_en while in REFILL/BYPASS are ignored; latched values are used.
- Async reset during REFILL/BYPASS: immediate return to IDLE, mem_req=0, lines invalid, partial line discarded.

Decomposition:
- Package icache_pkg:
  - state enum (IDLE, REFILL, BYPASS, BYP_DONE).
  - functions/localparams deriving OFF, IDX_W, TAG_W, WCNT_W from the parameters.
- Sub-module icache_array holds the valid/tag/data storage:
  - Async reset on the valid bits only.
  - Combinational read ports for tag, valid and data.
  - Synchronous write ports for data word, tag+valid set, and flush.
- icache_ctrl holds the FSM, counters, bypass register and output muxing.

Test Plan:
- Reset, cache_en=1, pc=0 → freeze=1. mem_addr sequence 0x0,0x4,0x8,0xC, with rvalid each cycle returning 0x11,0x22,0x33,0x44. One cycle after the last rvalid: hit=1, freeze=0, inst=0x11.
- After the fill, pc=0x8 → hit=1 the same cycle, inst=0x33, mem_req stays 0.
- pc=0x100 (same index, different tag) → miss; refill from 0x100..0x10C. Then pc=0x0 → miss again (conflict eviction).
- cache_en=0, pc=0x20, rvalid 3 cycles after the request with 0xDEADBEEF → exactly one cycle of freeze=0, inst=0xDEADBEEF, hit=0. A later cached fetch of 0x20 misses.
- flush asserted on the 3rd rvalid of a refill at pc=0x40 → refill completes, back in IDLE hit=0, freeze=1, new refill issued from 0x40.
- rst_b pulsed low after the 2nd rvalid of a refill → mem_req=0 immediately. After release, the prior pc misses and refill restarts at word 0.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the instruction cache controller.
package icache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRefill,
    StBypass,
    StBypDone
  } state_e;

  // Byte-offset width: word-in-line bits plus the two byte bits.
  function automatic int unsigned off_w(input int unsigned line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int unsigned idx_w(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned line_words,
                                        input int unsigned num_lines);
    return 32 - off_w(line_words) - idx_w(num_lines);
  endfunction

  function automatic int unsigned wcnt_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for a direct-mapped read-only cache.
// Only the valid bits are reset; tags and data are qualified by them.
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_LINES  = 16,
  localparam int unsigned IDX_W  = idx_w(NUM_LINES),
  localparam int unsigned TAG_W  = tag_w(LINE_WORDS, NUM_LINES),
  localparam int unsigned WCNT_W = wcnt_w(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [WCNT_W-1:0] rd_off,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [31:0]       rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WCNT_W-1:0] wr_off,
  input  logic [31:0]       wr_data,
  input  logic              set_en,
  input  logic [IDX_W-1:0]  set_idx,
  input  logic [TAG_W-1:0]  set_tag,
  input  logic              flush
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES][LINE_WORDS];

  // Flush takes priority over a simultaneous line validation.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (set_en) begin
      valid_q[set_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_idx][wr_off] <= wr_data;
    end
    if (set_en) begin
      tag_q[set_idx] <= set_tag;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx][rd_off];

endmodule

// File: rtl/icache_ctrl.sv
// Instruction cache controller: combinational lookup, word-serial line refill
// and an uncached bypass path, stalling the IF stage while memory is busy.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_LINES  = 16
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] pc,
  input  logic        cache_en,
  input  logic        flush,
  output logic [31:0] inst,
  output logic        hit,
  output logic        freeze,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned OFF    = off_w(LINE_WORDS);
  localparam int unsigned IDX_W  = idx_w(NUM_LINES);
  localparam int unsigned TAG_W  = tag_w(LINE_WORDS, NUM_LINES);
  localparam int unsigned WCNT_W = wcnt_w(LINE_WORDS);
  localparam logic [WCNT_W-1:0] LastWord = WCNT_W'(LINE_WORDS - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]       byp_q, byp_d;
  logic              sup_q, sup_d;
  logic              mem_req_q, mem_req_d;
  logic [31:0]       mem_addr_q, mem_addr_d;

  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  pc_tag;
  logic [WCNT_W-1:0] pc_off;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data;
  logic              fill_wr;
  logic              line_set;
  logic              unused_pc;

  assign pc_off    = pc[OFF-1:2];
  assign pc_idx    = pc[OFF+IDX_W-1:OFF];
  assign pc_tag    = pc[31:OFF+IDX_W];
  assign unused_pc = ^pc[1:0];

  icache_array #(
    .LINE_WORDS(LINE_WORDS),
    .NUM_LINES (NUM_LINES)
  ) u_array (
    .clk     (clk),
    .rst_b   (rst_b),
    .rd_idx  (pc_idx),
    .rd_off  (pc_off),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (fill_wr),
    .wr_idx  (idx_q),
    .wr_off  (cnt_q),
    .wr_data (mem_rdata),
    .set_en  (line_set),
    .set_idx (idx_q),
    .set_tag (tag_q),
    .flush   (flush)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tag_d      = tag_q;
    cnt_d      = cnt_q;
    byp_d      = byp_q;
    sup_d      = sup_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    hit        = 1'b0;
    freeze     = 1'b0;
    inst       = '0;
    fill_wr    = 1'b0;
    line_set   = 1'b0;

    unique case (state_q)
      StIdle: begin
        hit    = cache_en & rd_valid & (rd_tag == pc_tag);
        freeze = ~hit;
        if (hit) begin
          inst = rd_data;
        end
        if (!cache_en) begin
          mem_req_d  = 1'b1;
          mem_addr_d = {pc[31:2], 2'b00};
          state_d    = StBypass;
        end else if (!hit) begin
          idx_d      = pc_idx;
          tag_d      = pc_tag;
          cnt_d      = '0;
          sup_d      = 1'b0;
          mem_req_d  = 1'b1;
          mem_addr_d = {pc[31:OFF], {OFF{1'b0}}};
          state_d    = StRefill;
        end
      end
      StRefill: begin
        freeze = 1'b1;
        // A flush anywhere in the refill must keep this line from validating.
        if (flush) begin
          sup_d = 1'b1;
        end
        if (mem_rvalid) begin
          fill_wr = 1'b1;
          cnt_d   = cnt_q + WCNT_W'(1);
          if (cnt_q == LastWord) begin
            line_set  = ~sup_q & ~flush;
            mem_req_d = 1'b0;
            state_d   = StIdle;
          end else begin
            mem_addr_d = mem_addr_q + 32'd4;
          end
        end
      end
      StBypass: begin
        freeze = 1'b1;
        if (mem_rvalid) begin
          byp_d     = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = StBypDone;
        end
      end
      StBypDone: begin
        inst    = byp_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      tag_q      <= '0;
      cnt_q      <= '0;
      byp_q      <= '0;
      sup_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      byp_q      <= byp_d;
      sup_q      <= sup_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: table of hit lookups plus hand-written
// refill, bypass, flush and reset sequences against a scripted memory.
module tb_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] pc;
  logic        cache_en;
  logic        flush;
  logic [31:0] inst;
  logic        hit;
  logic        freeze;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  icache_ctrl #(
    .LINE_WORDS(4),
    .NUM_LINES (16)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .pc        (pc),
    .cache_en  (cache_en),
    .flush     (flush),
    .inst      (inst),
    .hit       (hit),
    .freeze    (freeze),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        en;
    logic        rv;
    logic [31:0] inst;
    logic        hit;
    logic        frz;
    logic        req;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Answer one memory word: wait for the request, hold for lat cycles, then
  // pulse rvalid (optionally with flush). Returns on the next negedge.
  task automatic serve(input string name, input logic [31:0] addr, input logic [31:0] data,
                       input int lat, input logic fl);
    int n = 0;
    mem_rvalid = 1'b0;
    while (!mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!mem_req) begin
      chk({name, " req timeout"}, mem_req, 1);
      return;
    end
    chk({name, " addr"}, mem_addr, addr);
    chk({name, " freeze"}, freeze, 1);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk({name, " hold req"}, mem_req, 1);
      chk({name, " hold addr"}, mem_addr, addr);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    flush      = fl;
    @(negedge clk);
    mem_rvalid = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic refill(input string name, input logic [31:0] base,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3,
                        input int lat, input int fw);
    serve({name, " w0"}, base,         d0, lat, fw == 0);
    serve({name, " w1"}, base + 32'h4, d1, lat, fw == 1);
    serve({name, " w2"}, base + 32'h8, d2, lat, fw == 2);
    serve({name, " w3"}, base + 32'hC, d3, lat, fw == 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{pc: 32'h8, en: 1'b1, rv: 1'b0, inst: 32'h33, hit: 1'b1, frz: 1'b0, req: 1'b0};
    vecs[1] = '{pc: 32'h4, en: 1'b1, rv: 1'b1, inst: 32'h22, hit: 1'b1, frz: 1'b0, req: 1'b0};
    vecs[2] = '{pc: 32'hC, en: 1'b1, rv: 1'b0, inst: 32'h44, hit: 1'b1, frz: 1'b0, req: 1'b0};
    vecs[3] = '{pc: 32'h0, en: 1'b1, rv: 1'b0, inst: 32'h11, hit: 1'b1, frz: 1'b0, req: 1'b0};
    vecs[4] = '{pc: 32'h104, en: 1'b1, rv: 1'b0, inst: 32'h0, hit: 1'b0, frz: 1'b1, req: 1'b0};

    rst_b      = 1'b0;
    pc         = 32'h0;
    cache_en   = 1'b1;
    flush      = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst inst", inst, 0);
    chk("rst hit", hit, 0);
    chk("rst freeze", freeze, 1);
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_addr", mem_addr, 0);
    rst_b = 1'b1;
    #1;
    chk("post-rst freeze", freeze, 1);

    // First fill, back-to-back rvalid
    refill("fill0", 32'h0, 32'h11, 32'h22, 32'h33, 32'h44, 0, -1);
    chk("fill0 hit", hit, 1);
    chk("fill0 freeze", freeze, 0);
    chk("fill0 inst", inst, 32'h11);
    chk("fill0 req", mem_req, 0);

    // Lookup table; last entry is a conflict miss on index 0
    for (int i = 0; i < 5; i++) begin
      pc         = vecs[i].pc;
      cache_en   = vecs[i].en;
      mem_rvalid = vecs[i].rv;
      #1;
      chk($sformatf("vec%0d inst", i), inst, vecs[i].inst);
      chk($sformatf("vec%0d hit", i), hit, vecs[i].hit);
      chk($sformatf("vec%0d freeze", i), freeze, vecs[i].frz);
      chk($sformatf("vec%0d req", i), mem_req, vecs[i].req);
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    pc = 32'h200;  // must be ignored while refilling
    refill("fill100", 32'h100, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 1, -1);
    pc = 32'h108;
    #1;
    chk("fill100 hit", hit, 1);
    chk("fill100 inst", inst, 32'hA3);
    @(negedge clk);
    pc = 32'h0;
    #1;
    chk("evict hit", hit, 0);
    chk("evict freeze", freeze, 1);
    refill("refill0", 32'h0, 32'h11, 32'h22, 32'h33, 32'h44, 0, -1);
    #1;
    chk("refill0 inst", inst, 32'h11);

    // Uncached bypass
    @(negedge clk);
    pc       = 32'h20;
    cache_en = 1'b0;
    #1;
    chk("byp idle freeze", freeze, 1);
    chk("byp idle hit", hit, 0);
    serve("byp", 32'h20, 32'hDEADBEEF, 3, 1'b0);
    #1;
    chk("byp done freeze", freeze, 0);
    chk("byp done inst", inst, 32'hDEADBEEF);
    chk("byp done hit", hit, 0);
    cache_en = 1'b1;
    @(negedge clk);
    #1;
    chk("byp after freeze", freeze, 1);
    chk("byp after hit", hit, 0);
    chk("byp after inst", inst, 0);
    refill("fill20", 32'h20, 32'h55, 32'h66, 32'h77, 32'h88, 0, -1);
    #1;
    chk("fill20 inst", inst, 32'h55);
    chk("fill20 hit", hit, 1);

    // Flush on third rvalid suppresses the line
    @(negedge clk);
    pc = 32'h40;
    #1;
    chk("fl miss freeze", freeze, 1);
    refill("fl3", 32'h40, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 0, 2);
    #1;
    chk("fl3 hit", hit, 0);
    chk("fl3 freeze", freeze, 1);
    refill("fl3 redo", 32'h40, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 0, -1);
    pc    = 32'h44;
    flush = 1'b1;
    #1;
    chk("idle flush hit", hit, 1);
    chk("idle flush inst", inst, 32'hC1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("after flush hit", hit, 0);
    chk("after flush freeze", freeze, 1);
    // Flush coinciding with the final word
    refill("fl4", 32'h40, 32'hD0, 32'hD1, 32'hD2, 32'hD3, 0, 3);
    #1;
    chk("fl4 hit", hit, 0);
    refill("fl4 redo", 32'h40, 32'hE0, 32'hE1, 32'hE2, 32'hE3, 0, -1);
    #1;
    chk("fl4 redo inst", inst, 32'hE1);
    chk("fl4 redo hit", hit, 1);

    // Async reset mid-refill
    @(negedge clk);
    pc = 32'h80;
    #1;
    chk("rr miss", hit, 0);
    serve("rr w0", 32'h80, 32'hF0, 0, 1'b0);
    serve("rr w1", 32'h84, 32'hF1, 0, 1'b0);
    rst_b = 1'b0;
    #1;
    chk("rr req", mem_req, 0);
    chk("rr hit", hit, 0);
    chk("rr inst", inst, 0);
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    chk("rr after hit", hit, 0);
    chk("rr after freeze", freeze, 1);
    refill("rr fill", 32'h80, 32'h90, 32'h91, 32'h92, 32'h93, 0, -1);
    #1;
    chk("rr fill inst", inst, 32'h90);
    chk("rr fill hit", hit, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
